// File: rtl/mips_wb_queue.sv
// rtl/mips_wb_queue.sv - in-order write-back queue with forwarding lookup for the MIPS register file
module mips_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_reg,
  input  logic [DW-1:0] in_data,
  input  logic          wb_hold,
  output logic          RegWrite,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  input  logic [AW-1:0] fwd_reg_a,
  output logic          fwd_hit_a,
  output logic [DW-1:0] fwd_data_a,
  input  logic [AW-1:0] fwd_reg_b,
  output logic          fwd_hit_b,
  output logic [DW-1:0] fwd_data_b,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [AW-1:0]    reg_q  [DEPTH];
  logic [AW-1:0]    reg_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  logic [PW-1:0]    idx;

  always_comb begin
    empty     = (count_q == '0);
    count     = count_q;
    in_ready  = !reset && (count_q < CW'(DEPTH));
    RegWrite  = !reset && !empty && !wb_hold;
    WriteReg  = empty ? '0 : reg_q[rd_ptr_q];
    WriteData = empty ? '0 : data_q[rd_ptr_q];
    push      = in_valid && in_ready;
    pop       = RegWrite;

    data_d   = data_q;
    reg_d    = reg_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Push is blocked when full and pop when empty, so wr and rd never alias here.
    if (push) begin
      data_d[wr_ptr_q]  = in_data;
      reg_d[wr_ptr_q]   = in_reg;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Walk oldest to newest so the youngest matching entry is the one left standing.
  always_comb begin
    idx        = '0;
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && (reg_q[idx] == fwd_reg_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = data_q[idx];
      end
      if (valid_q[idx] && (reg_q[idx] == fwd_reg_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = data_q[idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
    data_q <= data_d;
    reg_q  <= reg_d;
  end

endmodule

// File: tb/tb_mips_wb_queue.sv
// tb/tb_mips_wb_queue.sv - directed self-checking bench for mips_wb_queue
module tb_mips_wb_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        wb_hold;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  fwd_reg_a;
  logic        fwd_hit_a;
  logic [31:0] fwd_data_a;
  logic [4:0]  fwd_reg_b;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_b;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;
  logic [4:0]  log_reg  [$];
  logic [31:0] log_data [$];

  mips_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wb_hold(wb_hold),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .fwd_reg_a(fwd_reg_a), .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .fwd_reg_b(fwd_reg_b), .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
    .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  // Register-file model: captures writes on the falling edge.
  always @(negedge clock) begin
    if (RegWrite === 1'b1) begin
      log_reg.push_back(WriteReg);
      log_data.push_back(WriteData);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_reg.delete();
    log_data.delete();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_reg = 5'd9; in_data = 32'hDEAD;
    wb_hold = 1'b0; fwd_reg_a = 5'd9; fwd_reg_b = 5'd0;
    #1;
    chk("ready_in_reset", in_ready, 0);
    tick();
    tick();
    chk("regwrite_in_reset", RegWrite, 0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_writereg", WriteReg, 0);
    chk("reset_writedata", WriteData, 0);
    chk("reset_hit_a", fwd_hit_a, 0);
    chk("reset_data_a", fwd_data_a, 0);
    chk("reset_ready", in_ready, 1);

    // 1: single push, one write next cycle
    clear_log();
    in_valid = 1'b1; in_reg = 5'd3; in_data = 32'hAAAA;
    chk("t1_no_bypass", RegWrite, 0);
    tick();
    in_valid = 1'b0;
    chk("t1_regwrite", RegWrite, 1);
    chk("t1_writereg", WriteReg, 3);
    chk("t1_writedata", WriteData, 32'hAAAA);
    tick();
    chk("t1_empty", empty, 1);
    chk("t1_regwrite_off", RegWrite, 0);
    chk("t1_nwrites", log_reg.size(), 1);

    // 2: fill under hold, refuse 5th, drain in order
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg = 5'(10 + i); in_data = 32'h100 + i;
      tick();
    end
    chk("t2_count_full", count, 4);
    chk("t2_ready_full", in_ready, 0);
    chk("t2_held_regwrite", RegWrite, 0);
    in_reg = 5'd20; in_data = 32'h999;
    tick();
    in_valid = 1'b0;
    chk("t2_refused_count", count, 4);
    fwd_reg_a = 5'd10;
    #1;
    chk("t2_head_fwd_hit", fwd_hit_a, 1);
    chk("t2_head_fwd_data", fwd_data_a, 32'h100);
    fwd_reg_a = 5'd20;
    #1;
    chk("t2_refused_fwd", fwd_hit_a, 0);
    clear_log();
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t2_nwrites", log_reg.size(), 4);
    for (int i = 0; i < 4 && i < log_reg.size(); i++) begin
      chk("t2_wr_reg", log_reg[i], 10 + i);
      chk("t2_wr_data", log_data[i], 32'h100 + i);
    end
    chk("t2_empty", empty, 1);

    // 3 + 6: duplicate destination forwarding, port B miss
    wb_hold = 1'b1;
    in_valid = 1'b1; in_reg = 5'd5; in_data = 32'd1;
    tick();
    in_data = 32'd2;
    tick();
    in_valid = 1'b0;
    fwd_reg_a = 5'd5; fwd_reg_b = 5'd7;
    #1;
    chk("t3_hit_a", fwd_hit_a, 1);
    chk("t3_data_a", fwd_data_a, 2);
    chk("t6_hit_b", fwd_hit_b, 0);
    chk("t6_data_b", fwd_data_b, 0);
    fwd_reg_b = 5'd5;
    #1;
    chk("t6_hit_b_match", fwd_hit_b, 1);
    chk("t6_data_b_match", fwd_data_b, 2);
    clear_log();
    wb_hold = 1'b0;
    tick();
    chk("t3_mid_hit_a", fwd_hit_a, 1);
    chk("t3_mid_data_a", fwd_data_a, 2);
    tick();
    chk("t3_nwrites", log_reg.size(), 2);
    if (log_data.size() == 2) begin
      chk("t3_first", log_data[0], 1);
      chk("t3_second", log_data[1], 2);
    end
    chk("t3_hit_a_gone", fwd_hit_a, 0);
    chk("t3_data_a_gone", fwd_data_a, 0);

    // 4: steady state push+pop at count 2 across pointer wrap
    wb_hold = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_reg = 5'(1 + i); in_data = 32'h10 + i;
      tick();
    end
    clear_log();
    wb_hold = 1'b0;
    for (int i = 2; i < 8; i++) begin
      in_reg = 5'(1 + i); in_data = 32'h10 + i;
      tick();
      chk("t4_count", count, 2);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("t4_nwrites", log_data.size(), 8);
    for (int i = 0; i < 8 && i < log_data.size(); i++) begin
      chk("t4_order", log_data[i], 32'h10 + i);
      chk("t4_reg", log_reg[i], 1 + i);
    end

    // 5: reset with three entries queued
    wb_hold = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_reg = 5'(0 + i); in_data = 32'h700 + i;
      tick();
    end
    in_valid = 1'b0;
    clear_log();
    wb_hold = 1'b0; reset = 1'b1;
    #1;
    chk("t5_regwrite_in_reset", RegWrite, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    fwd_reg_a = 5'd1;
    #1;
    chk("t5_fwd_cleared", fwd_hit_a, 0);
    tick();
    tick();
    tick();
    chk("t5_no_writes", log_reg.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
